rgb_led_seq: RTL and testbench

Parametrised RGB status-LED controller for the FPGA board's tri-colour LED. Provides selectable display modes (off, solid, blink, colour cycle) and per-frame PWM brightness dimming. Drives the LED pins directly from registered outputs. Host logic (SPI register block or top-level glue) configures it with a single write strobe.

---
 rtl/rgb_led_seq.sv | 95 +++++++++
 tb/tb_rgb_led_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rgb_led_seq.sv
// Tri-colour status LED controller: off / solid / blink / colour-cycle modes
// with per-frame PWM dimming, registered pin drive.
module rgb_led_seq #(
  parameter int unsigned STEP_TICKS = 5_500_000,
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_mode,
  input  logic [2:0]          cfg_color,
  input  logic [PWM_BITS-1:0] cfg_bright,
  output logic                step_tick,
  output logic [2:0]          led
);

  localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0]    STEP_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = {PWM_BITS{1'b1}};
  localparam logic [2:0]          LED_DARK   = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CYCLE = 2'd3
  } mode_e;

  mode_e               mode;
  logic [2:0]          color;
  logic [PWM_BITS-1:0] bright;
  logic [CNT_W-1:0]    step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic [2:0]          cyc_color;

  logic                step_wrap;
  logic [2:0]          logical;
  logic                gate;
  logic [2:0]          lit;
  logic [2:0]          led_d;

  // Colour selection, dimming gate and pin polarity.
  always_comb begin
    step_wrap = (step_cnt == STEP_LAST);
    logical   = 3'b000;
    unique case (mode)
      MODE_OFF:   logical = 3'b000;
      MODE_SOLID: logical = color;
      MODE_BLINK: logical = phase ? 3'b000 : color;
      MODE_CYCLE: logical = cyc_color;
      default:    logical = 3'b000;
    endcase
    gate  = (bright == BRIGHT_MAX) || (pwm_cnt < bright);
    lit   = logical & {3{gate}};
    led_d = ACTIVE_LOW ? ~lit : lit;
  end

  // Config latch, step/PWM timing and registered outputs; a write restarts timing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode      <= MODE_OFF;
      color     <= 3'b000;
      bright    <= BRIGHT_MAX;
      step_cnt  <= '0;
      pwm_cnt   <= '0;
      phase     <= 1'b0;
      cyc_color <= 3'd1;
      step_tick <= 1'b0;
      led       <= LED_DARK;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led     <= led_d;
      if (cfg_we) begin
        mode      <= mode_e'(cfg_mode);
        color     <= cfg_color;
        bright    <= cfg_bright;
        step_cnt  <= '0;
        phase     <= 1'b0;
        cyc_color <= 3'd1;
        step_tick <= 1'b0;
      end else if (step_wrap) begin
        step_cnt  <= '0;
        phase     <= ~phase;
        cyc_color <= (cyc_color == 3'd7) ? 3'd1 : cyc_color + 3'd1;
        step_tick <= 1'b1;
      end else begin
        step_cnt  <= step_cnt + CNT_W'(1);
        step_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_led_seq.sv
// Directed bench: active-low and active-high instances share stimulus,
// expected pin values are hand-derived per step.
module tb_rgb_led_seq;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       cfg_we;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_color;
  logic [1:0] cfg_bright;
  logic       st_lo, st_hi;
  logic [2:0] led_lo, led_hi;

  int total = 0;
  int bad   = 0;

  rgb_led_seq #(.STEP_TICKS(4), .PWM_BITS(2), .ACTIVE_LOW(1'b1)) u_lo (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we),
    .cfg_mode(cfg_mode), .cfg_color(cfg_color), .cfg_bright(cfg_bright),
    .step_tick(st_lo), .led(led_lo));

  rgb_led_seq #(.STEP_TICKS(4), .PWM_BITS(2), .ACTIVE_LOW(1'b0)) u_hi (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we),
    .cfg_mode(cfg_mode), .cfg_color(cfg_color), .cfg_bright(cfg_bright),
    .step_tick(st_hi), .led(led_hi));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Active-low pins must match exp; active-high pins the inverse.
  task automatic chk_led(input string tag, input logic [2:0] exp);
    chk(tag, {5'b0, led_lo}, {5'b0, exp});
    chk({tag, "_hi"}, {5'b0, led_hi}, {5'b0, ~exp});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] m, input logic [2:0] c, input logic [1:0] b);
    cfg_we = 1'b1; cfg_mode = m; cfg_color = c; cfg_bright = b;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    int nbad_led, nt_lo, nt_hi, first, nlit, nother;
    logic [2:0] exp;
    sys_rst_n = 1'b1; cfg_we = 1'b0; cfg_mode = 2'd0; cfg_color = 3'd0; cfg_bright = 2'd0;
    #1 sys_rst_n = 1'b0;
    #2;
    chk_led("rst_async", 3'b111);
    chk("rst_tick", {7'b0, st_lo}, 8'd0);
    cyc(2);
    sys_rst_n = 1'b1;

    // 1: idle after reset
    nbad_led = 0; nt_lo = 0; nt_hi = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (led_lo !== 3'b111 || led_hi !== 3'b000) nbad_led++;
      if (st_lo) begin nt_lo++; if (first == 0) first = i; end
      if (st_hi) nt_hi++;
    end
    chk("idle_led_bad", 8'(nbad_led), 8'd0);
    chk("idle_ticks", 8'(nt_lo), 8'd5);
    chk("idle_ticks_hi", 8'(nt_hi), 8'd5);
    chk("idle_first_tick", 8'(first), 8'd4);

    // 2: solid red
    wr(2'd1, 3'b001, 2'b11);
    for (int i = 0; i < 8; i++) begin cyc(1); chk_led($sformatf("solid%0d", i), 3'b110); end

    // 3: blink green, lit half first
    wr(2'd2, 3'b100, 2'd3);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk_led($sformatf("blink%0d", i), ((i / 4) % 2 == 0) ? 3'b011 : 3'b111);
    end

    // 4: colour cycle 1..7 then wrap to 1
    wr(2'd3, 3'b000, 2'd3);
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      exp = ~(3'((i / 4) % 7 + 1));
      chk_led($sformatf("cycle%0d", i), exp);
    end
    cyc(6);
    wr(2'd3, 3'b000, 2'd3);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk_led($sformatf("cycle_rs%0d", i), (i < 4) ? 3'b110 : 3'b101);
    end

    // 5: PWM dimming, bright=1 then 2 then 0
    wr(2'd1, 3'b111, 2'b01);
    nlit = 0; nother = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (led_lo === 3'b000) nlit++; else if (led_lo !== 3'b111) nother++;
    end
    chk("pwm1_lit", 8'(nlit), 8'd4);
    chk("pwm1_other", 8'(nother), 8'd0);
    wr(2'd1, 3'b111, 2'b10);
    nlit = 0;
    for (int i = 0; i < 16; i++) begin cyc(1); if (led_lo === 3'b000) nlit++; end
    chk("pwm2_lit", 8'(nlit), 8'd8);
    wr(2'd1, 3'b111, 2'b00);
    for (int i = 0; i < 8; i++) begin cyc(1); chk_led($sformatf("pwm0_%0d", i), 3'b111); end

    // 6a: write coincident with step wrap restarts blink at phase 0
    wr(2'd2, 3'b001, 2'd3);
    cyc(3);
    wr(2'd2, 3'b001, 2'd3);
    chk("coinc_no_tick", {7'b0, st_lo}, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk($sformatf("coinc_tick%0d", i), {7'b0, st_lo}, (i == 4 || i == 8) ? 8'd1 : 8'd0);
      chk_led($sformatf("coinc_led%0d", i), (i <= 4) ? 3'b110 : 3'b111);
    end

    // 6b: reset mid-blink
    wr(2'd2, 3'b001, 2'd3);
    cyc(2);
    chk_led("preblink", 3'b110);
    sys_rst_n = 1'b0;
    #1;
    chk_led("midrst_async", 3'b111);
    chk("midrst_tick", {7'b0, st_lo}, 8'd0);
    cyc(2);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin cyc(1); chk_led($sformatf("postrst%0d", i), 3'b111); end
    wr(2'd1, 3'b010, 2'd3);
    cyc(1);
    chk_led("postrst_solid", 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
